// File: rtl/host_reg_master.sv
// Register-bus master: queues read/write commands, runs them with programmable wait
// states, and offers a hardware read sweep of indices 0..SWEEP_LAST plus access counters.
module host_reg_master #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 7,
  parameter int unsigned ADDR_SHIFT  = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned SWEEP_LAST  = 34,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     clk_reg,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [AW-1:0]            cmd_addr,
  input  logic [DW-1:0]            cmd_wdata,
  input  logic                     sweep_start,
  output logic                     sweep_done,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [AW-1:0]            rsp_addr,
  output logic [DW-1:0]            rsp_data,
  output logic [CNT_W-1:0]         wr_count,
  output logic [CNT_W-1:0]         rd_count,
  output logic                     csb,
  output logic                     wrb,
  output logic [DW-1:0]            cd_in,
  input  logic [DW-1:0]            cd_out,
  output logic [AW+ADDR_SHIFT-1:0] ca
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CAW = AW + ADDR_SHIFT;

  typedef enum logic [1:0] {StIdle, StStrobe, StRecover} state_e;

  // Command FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic            mem_wr   [DEPTH];
  logic [AW-1:0]   mem_addr [DEPTH];
  logic [DW-1:0]   mem_data [DEPTH];
  logic [PW:0]     wptr_q, rptr_q;
  logic            fifo_full, fifo_empty, push, pop;

  state_e          state_q;
  logic [3:0]      wait_q;
  logic            sweep_active_q, cur_last_q, cur_wr_q;
  logic [AW-1:0]   sweep_idx_q, cur_idx_q;
  logic            csb_q, wrb_q, rsp_valid_q, sweep_done_q;
  logic [CAW-1:0]  ca_q;
  logic [DW-1:0]   cd_in_q, rsp_data_q;
  logic [AW-1:0]   rsp_addr_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;

  logic            issue_go, issue_wr;
  logic [AW-1:0]   issue_idx;
  logic [DW-1:0]   issue_data;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push       = cmd_valid && !fifo_full;
  assign issue_go   = (state_q == StIdle) && (sweep_active_q || !fifo_empty);
  assign pop        = issue_go && !sweep_active_q;
  assign busy       = (state_q != StIdle) || !fifo_empty || sweep_active_q;

  // Sweep reads take priority over queued commands at every idle decision.
  always_comb begin
    issue_wr   = 1'b0;
    issue_idx  = sweep_idx_q;
    issue_data = '0;
    if (!sweep_active_q) begin
      issue_wr   = mem_wr[rptr_q[PW-1:0]];
      issue_idx  = mem_addr[rptr_q[PW-1:0]];
      issue_data = mem_data[rptr_q[PW-1:0]];
    end
  end

  always_ff @(posedge clk_reg) begin
    if (push) begin
      mem_wr[wptr_q[PW-1:0]]   <= cmd_wr;
      mem_addr[wptr_q[PW-1:0]] <= cmd_addr;
      mem_data[wptr_q[PW-1:0]] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk_reg or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_reg or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      wait_q         <= '0;
      sweep_active_q <= 1'b0;
      sweep_idx_q    <= '0;
      cur_last_q     <= 1'b0;
      cur_wr_q       <= 1'b0;
      cur_idx_q      <= '0;
      csb_q          <= 1'b1;
      wrb_q          <= 1'b1;
      ca_q           <= '0;
      cd_in_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_addr_q     <= '0;
      rsp_data_q     <= '0;
      sweep_done_q   <= 1'b0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
    end else begin
      rsp_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      if (sweep_start && !busy) begin
        sweep_active_q <= 1'b1;
        sweep_idx_q    <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (issue_go) begin
            state_q    <= StStrobe;
            wait_q     <= 4'(WAIT_CYCLES);
            csb_q      <= 1'b0;
            wrb_q      <= !issue_wr;
            ca_q       <= CAW'(issue_idx) << ADDR_SHIFT;
            cd_in_q    <= issue_wr ? issue_data : '0;
            cur_wr_q   <= issue_wr;
            cur_idx_q  <= issue_idx;
            cur_last_q <= sweep_active_q && (sweep_idx_q == AW'(SWEEP_LAST));
            if (sweep_active_q) sweep_idx_q <= sweep_idx_q + AW'(1);
          end
        end
        StStrobe: begin
          if (wait_q == 4'd0) begin
            state_q <= StRecover;
            csb_q   <= 1'b1;
            wrb_q   <= 1'b1;
            if (cur_wr_q) begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_addr_q  <= cur_idx_q;
              rsp_data_q  <= cd_out;
              rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StRecover: begin
          state_q <= StIdle;
          if (cur_last_q) begin
            sweep_active_q <= 1'b0;
            sweep_done_q   <= 1'b1;
            cur_last_q     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign csb        = csb_q;
  assign wrb        = wrb_q;
  assign ca         = ca_q;
  assign cd_in      = cd_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_data   = rsp_data_q;
  assign sweep_done = sweep_done_q;
  assign wr_count   = wr_cnt_q;
  assign rd_count   = rd_cnt_q;

endmodule
